rr_sel_scheduler: RTL and testbench
===================================

# rr_sel_scheduler

Round-robin slot scheduler that generates the 2-bit `sel` for the 4:1 mux / 1:4 demux channel path and captures the routed channel's value at the end of each slot. It sits directly upstream of the mux/demux pair and drives its `sel`. It also consumes the demux outputs (`out1..out4`) and presents one registered sample per channel. Arbitration is fair: no requesting channel waits more than three slots.

## Interface
- `SLOT_LEN`, default 4: cycles each grant is held, legal range 1..255.
- `CW`, default 8: width of the slot counter; must satisfy `2**CW >= SLOT_LEN`.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: scheduler enable; sampled every cycle.
- `req`  in  4: per-channel request; bit0 = channel a, bit3 = channel d.
- `dmx_in`  in  4: demux outputs `{out4,out3,out2,out1}`.
- `sel`  out  2: channel select to the mux/demux.
- `sel_valid`  out  1: `sel` addresses a granted slot.
- `grant`  out  4: one-hot of `sel` while `sel_valid`, else 0.
- `slot_last`  out  1: final cycle of the current slot.
- `sample_q`  out  4: last captured value per channel.
- `sample_stb`  out  1: one-cycle pulse when `sample_q` is updated.

## Operation
- All outputs are registered. Reset values:
  - `sel`=2'b00, `sel_valid`=0, `grant`=4'b0000, `slot_last`=0, `sample_q`=4'b0000, `sample_stb`=0.
  - Internal: `ptr`=0, `cnt`=0, state=IDLE.
- State machine, two states:
  - IDLE → GRANT when `en`=1 and `req`≠0. Otherwise stay in IDLE.
  - GRANT → GRANT on the last slot cycle when `en`=1 and `req`≠0. This is a back-to-back grant with no bubble.
  - GRANT → IDLE on the last slot cycle otherwise.
- Round-robin pick: the first set bit of `req` scanning `ptr`, `ptr+1`, … modulo 4, using 2-bit wrap-around (3+1=0). On each grant, `ptr` ← granted index + 1.
- The slot is non-preemptive. Dropping `req` or deasserting `en` mid-slot does not shorten it; the slot runs all `SLOT_LEN` cycles.
- `cnt` counts 0..`SLOT_LEN`-1 within GRANT. `slot_last`=1 when `cnt`==`SLOT_LEN`-1. With `SLOT_LEN`=1, `slot_last` is high on every GRANT cycle.
- Capture: on a cycle where `slot_last`=1, `sample_q[sel]` ← `dmx_in[sel]`. Other bits of `sample_q` hold. `sample_stb` pulses on the following cycle, together with the new `sample_q`.
- `sel` holds its last granted value in IDLE. Downstream must qualify `sel` with `sel_valid`.
- `rst` asserted mid-slot aborts the slot with no capture. All values return to reset on the next edge.
- When `rst` and `req` are both high, `rst` wins. Arbitration starts on the first cycle after `rst` deasserts.

## Timing
- Grant latency: `req`/`en` seen in IDLE at edge N gives `sel`/`sel_valid`/`grant` valid after edge N+1.
- Slot length is exactly `SLOT_LEN` cycles of `sel_valid`=1 per grant.
- Back-to-back slots keep `sel_valid`=1 continuously; `sel` changes on the edge after `slot_last`.
- Capture timing: `dmx_in` is sampled on the `slot_last` cycle, so the mux/demux path has `SLOT_LEN` cycles to settle. `sample_q` and `sample_stb` update one cycle later.
- Worst-case wait for a continuously requesting channel: 3×`SLOT_LEN` cycles plus the 1-cycle grant latency.

## Test plan
- Reset check: `rst`=1 for 3 cycles with `req`=4'b1111 → all outputs hold their reset values. The first grant is `sel`=00, valid one cycle after `rst` falls.
- Full rotation: `SLOT_LEN`=4, `en`=1, `req`=4'b1111 →
  - `sel` sequence 00,01,10,11,00 with 4 cycles each.
  - `sel_valid` never drops.
  - `slot_last` is high every 4th cycle.
- Skip and wrap: `req`=4'b1010 with `ptr`=0 → `sel` goes 01 then 11 then 01. Channels 0 and 2 are never granted.
- Capture: grant channel 2 and drive `dmx_in`=4'b0100 on its `slot_last` cycle → next cycle `sample_q`=4'b0100 and `sample_stb`=1 for exactly one cycle. The other bits are unchanged.
- Mid-slot events:
  - Drop `req` at `cnt`=1 → the slot still lasts 4 cycles, then IDLE with `sel_valid`=0.
  - Repeat with `en`=0 at `cnt`=1 → same result.
  - Repeat with `rst`=1 at `cnt`=2 → next cycle all outputs are at reset values and `sample_stb` stays 0.
- `SLOT_LEN`=1 with `req`=4'b0001 → `sel`=00 and `slot_last`=1 every cycle. `sample_stb` pulses every cycle, one cycle delayed.

Source files
------------

// File: rtl/rr_sel_scheduler.sv
// Round-robin slot scheduler: drives sel for the 4:1 mux / 1:4 demux path and
// captures the routed channel's demux output on the last cycle of every slot.
module rr_sel_scheduler #(
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic [3:0] dmx_in,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [3:0] grant,
  output logic       slot_last,
  output logic [3:0] sample_q,
  output logic       sample_stb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST          = CW'(SLOT_LEN - 1);
  localparam logic          FIRST_IS_LAST = (SLOT_LEN == 1);

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          go;
  logic [1:0]    pick;
  logic [3:0]    pick_onehot;

  // Arbitration: scan from the farthest offset down so the lowest offset from
  // ptr is the one left standing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    go          = en && (req != 4'b0000);
    pick        = ptr;
    cnt_nxt     = cnt + CW'(1);
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        pick = ptr + 2'(i);
      end
    end
    pick_onehot = 4'b0001 << pick;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'b00;
      cnt        <= '0;
      sel        <= 2'b00;
      sel_valid  <= 1'b0;
      grant      <= 4'b0000;
      slot_last  <= 1'b0;
      sample_q   <= 4'b0000;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state     <= GRANT;
            ptr       <= pick + 2'd1;
            cnt       <= '0;
            sel       <= pick;
            sel_valid <= 1'b1;
            grant     <= pick_onehot;
            slot_last <= FIRST_IS_LAST;
          end
        end
        GRANT: begin
          if (slot_last) begin
            // The routed channel has had the whole slot to settle.
            sample_q[sel] <= dmx_in[sel];
            sample_stb    <= 1'b1;
            if (go) begin
              ptr       <= pick + 2'd1;
              cnt       <= '0;
              sel       <= pick;
              grant     <= pick_onehot;
              slot_last <= FIRST_IS_LAST;
            end else begin
              state     <= IDLE;
              cnt       <= '0;
              sel_valid <= 1'b0;
              grant     <= 4'b0000;
              slot_last <= 1'b0;
            end
          end else begin
            cnt       <= cnt_nxt;
            slot_last <= (cnt_nxt == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_scheduler.sv
// Self-checking bench for rr_sel_scheduler: directed table, corner sequences and
// random stimulus against a slot-countdown reference model (SLOT_LEN 4 and 1).
module tb_rr_sel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    = 1'b1;
  logic       en     = 1'b0;
  logic [3:0] req    = 4'b0000;
  logic [3:0] dmx_in = 4'b0000;

  logic [1:0] sel_a,  sel_b;
  logic       valid_a, valid_b;
  logic [3:0] grant_a, grant_b;
  logic       last_a, last_b;
  logic [3:0] sq_a,   sq_b;
  logic       stb_a,  stb_b;

  rr_sel_scheduler #(.SLOT_LEN(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .dmx_in(dmx_in),
    .sel(sel_a), .sel_valid(valid_a), .grant(grant_a), .slot_last(last_a),
    .sample_q(sq_a), .sample_stb(stb_a)
  );

  rr_sel_scheduler #(.SLOT_LEN(1), .CW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .dmx_in(dmx_in),
    .sel(sel_b), .sel_valid(valid_b), .grant(grant_b), .slot_last(last_b),
    .sample_q(sq_b), .sample_stb(stb_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a slot is "busy with N cycles left"; no FSM encoding.
  typedef struct {
    bit       busy;
    int       left;
    int       sel;
    int       ptr;
    bit [3:0] sample;
    bit       stb;
  } model_t;

  model_t m4, m1;

  typedef struct {
    bit          r;
    bit          e;
    bit [3:0]    rq;
    bit [3:0]    d;
    logic [12:0] exp;
  } vec_t;

  function automatic model_t model_step(input model_t m, input bit r, input bit e,
                                        input bit [3:0] rq, input bit [3:0] d,
                                        input int slot_len);
    model_t n;
    n = m;
    if (r) begin
      n.busy = 0; n.left = 0; n.sel = 0; n.ptr = 0; n.sample = 4'b0000; n.stb = 0;
      return n;
    end
    n.stb = 0;
    if (m.busy && m.left == 1) begin
      n.sample[m.sel] = d[m.sel];
      n.stb = 1;
    end
    if (!m.busy || m.left == 1) begin
      n.busy = 0;
      if (e && rq != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m.ptr + k) % 4;
          if (rq[idx] && !n.busy) begin
            n.busy = 1;
            n.sel  = idx;
            n.ptr  = (idx + 1) % 4;
            n.left = slot_len;
          end
        end
      end
    end else begin
      n.left = m.left - 1;
    end
    return n;
  endfunction

  function automatic logic [12:0] model_out(input model_t m);
    logic [3:0] g;
    g = m.busy ? (4'b0001 << m.sel) : 4'b0000;
    return {2'(m.sel), m.busy, g, (m.busy && m.left == 1), m.sample, m.stb};
  endfunction

  function automatic vec_t mk(input bit r, input bit e, input bit [3:0] rq,
                              input bit [3:0] d, input bit [1:0] s, input bit v,
                              input bit [3:0] g, input bit sl, input bit [3:0] sq,
                              input bit stb);
    vec_t t;
    t.r = r; t.e = e; t.rq = rq; t.d = d;
    t.exp = {s, v, g, sl, sq, stb};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] out_a();
    return {sel_a, valid_a, grant_a, last_a, sq_a, stb_a};
  endfunction

  function automatic logic [12:0] out_b();
    return {sel_b, valid_b, grant_b, last_b, sq_b, stb_b};
  endfunction

  // Drive one cycle of inputs, clock it, advance both models and compare.
  task automatic apply(input bit r, input bit e, input bit [3:0] rq, input bit [3:0] d);
    rst = r; en = e; req = rq; dmx_in = d;
    @(posedge clk);
    #1;
    m4 = model_step(m4, r, e, rq, d, 4);
    m1 = model_step(m1, r, e, rq, d, 1);
    check("model_slot4", 32'(out_a()), 32'(model_out(m4)));
    check("model_slot1", 32'(out_b()), 32'(model_out(m1)));
  endtask

  vec_t tbl[20];

  initial begin
    int nvalid;
    int bad_grants;
    int stb_cnt;
    logic [1:0] wrap_exp [3];

    // Reset with all requests, then a full rotation; expected values by hand.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1, 1, 4'hF, 4'h0, 2'd0, 0, 4'b0000, 0, 4'b0000, 0);
    tbl[3]  = mk(0, 1, 4'hF, 4'h0, 2'd0, 1, 4'b0001, 0, 4'b0000, 0);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = mk(0, 1, 4'hF, 4'h0, 2'd0, 1, 4'b0001, 1, 4'b0000, 0);
    tbl[7]  = mk(0, 1, 4'hF, 4'hF, 2'd1, 1, 4'b0010, 0, 4'b0001, 1);
    tbl[8]  = mk(0, 1, 4'hF, 4'h0, 2'd1, 1, 4'b0010, 0, 4'b0001, 0);
    tbl[9]  = tbl[8];
    tbl[10] = mk(0, 1, 4'hF, 4'h0, 2'd1, 1, 4'b0010, 1, 4'b0001, 0);
    tbl[11] = mk(0, 1, 4'hF, 4'h0, 2'd2, 1, 4'b0100, 0, 4'b0001, 1);
    tbl[12] = mk(0, 1, 4'hF, 4'h0, 2'd2, 1, 4'b0100, 0, 4'b0001, 0);
    tbl[13] = tbl[12];
    tbl[14] = mk(0, 1, 4'hF, 4'h0, 2'd2, 1, 4'b0100, 1, 4'b0001, 0);
    tbl[15] = mk(0, 1, 4'hF, 4'hF, 2'd3, 1, 4'b1000, 0, 4'b0101, 1);
    tbl[16] = mk(0, 1, 4'hF, 4'h0, 2'd3, 1, 4'b1000, 0, 4'b0101, 0);
    tbl[17] = tbl[16];
    tbl[18] = mk(0, 1, 4'hF, 4'h0, 2'd3, 1, 4'b1000, 1, 4'b0101, 0);
    tbl[19] = mk(0, 1, 4'hF, 4'h0, 2'd0, 1, 4'b0001, 0, 4'b0101, 1);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].rq, tbl[i].d);
      check($sformatf("table[%0d]", i), 32'(out_a()), 32'(tbl[i].exp));
    end

    // Skip and wrap: only channels 1 and 3 requesting.
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd3; wrap_exp[2] = 2'd1;
    bad_grants = 0;
    apply(1, 0, 4'h0, 4'h0);
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        apply(0, 1, 4'b1010, 4'h0);
        if (c == 0) check($sformatf("wrap_sel[%0d]", s), 32'(sel_a), 32'(wrap_exp[s]));
        if (grant_a[0] || grant_a[2]) bad_grants++;
      end
    end
    check("wrap_no_even_grant", bad_grants, 0);

    // Capture on channel 2 must leave the previously captured channel 0 bit alone.
    apply(1, 0, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) apply(0, 1, 4'b0001, 4'h0);
    apply(0, 1, 4'b0100, 4'b0001);
    for (int c = 0; c < 3; c++) apply(0, 1, 4'b0000, 4'h0);
    apply(0, 1, 4'b0000, 4'b0100);
    check("capture_q", 32'(sq_a), 32'h5);
    check("capture_stb", 32'(stb_a), 32'h1);
    apply(0, 1, 4'b0000, 4'h0);
    check("capture_stb_once", 32'(stb_a), 32'h0);

    // Mid-slot request drop, then mid-slot enable drop: slot still runs 4 cycles.
    for (int mode = 0; mode < 2; mode++) begin
      apply(1, 0, 4'h0, 4'h0);
      nvalid = 0;
      apply(0, 1, 4'b0001, 4'h0); nvalid += int'(valid_a);
      apply(0, 1, 4'b0001, 4'h0); nvalid += int'(valid_a);
      for (int c = 0; c < 4; c++) begin
        if (mode == 0) apply(0, 1, 4'b0000, 4'h0);
        else           apply(0, 0, 4'b0001, 4'h0);
        nvalid += int'(valid_a);
      end
      check($sformatf("midslot_len[%0d]", mode), nvalid, 4);
      check($sformatf("midslot_idle[%0d]", mode), 32'({valid_a, grant_a}), 32'h0);
    end

    // Reset mid-slot aborts with no capture.
    apply(1, 0, 4'h0, 4'h0);
    apply(0, 1, 4'b0001, 4'h1);
    apply(0, 1, 4'b0001, 4'h1);
    apply(0, 1, 4'b0001, 4'h1);
    apply(1, 1, 4'b0001, 4'h1);
    check("rst_midslot", 32'(out_a()), 32'h0);
    apply(0, 0, 4'b0000, 4'h1);
    check("rst_midslot_after", 32'(out_a()), 32'h0);

    // SLOT_LEN=1: every cycle is a last cycle, strobe trails by one.
    apply(1, 0, 4'h0, 4'h0);
    stb_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      apply(0, 1, 4'b0001, 4'b0001);
      check($sformatf("s1_sel_last[%0d]", c), 32'({sel_b, last_b}), 32'h1);
      stb_cnt += int'(stb_b);
    end
    check("s1_stb_count", stb_cnt, 4);
    check("s1_sample", 32'(sq_b), 32'h1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, rq, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
